// File: rtl/mul8_pipe.sv
// Unsigned 8x8 -> 16-bit pipelined array multiplier built from AND partial products and ripple
// adder rows. Define MUL8_PIPE_SELFCHECK_EN to add a parallel behavioural reference and err flag.
module mul8_pipe #(
  parameter int unsigned PIPE_MID = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  output logic [15:0] dout,
  output logic        err
);

  // Bitwise full-adder chain; the datapath never uses the '*' operator.
  function automatic logic [15:0] rca16(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] s;
    logic        c;
    c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return s;
  endfunction

  function automatic logic [15:0] pp_row(input logic [7:0] av, input logic bi, input int sh);
    logic [15:0] r;
    r = {8'h00, av & {8{bi}}};
    return r << sh;
  endfunction

  logic [7:0]  a0_d, a0_q, b0_d, b0_q;
  logic        v0_d, v0_q;
  logic [15:0] lo_sum, hi_sum, psum_s;
  logic [7:0]  a_s;
  logic [3:0]  bh_s;
  logic        v_s;
  logic [15:0] dout_d, dout_q;
  logic        ov_d, ov_q;

  always_comb begin
    a0_d = a;
    b0_d = b;
    v0_d = in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q <= 8'h00;
      b0_q <= 8'h00;
      v0_q <= 1'b0;
    end else begin
      a0_q <= a0_d;
      b0_q <= b0_d;
      v0_q <= v0_d;
    end
  end

  always_comb begin
    lo_sum = 16'h0000;
    for (int i = 0; i < 4; i++) lo_sum = rca16(lo_sum, pp_row(a0_q, b0_q[i], i));
  end

`ifdef MUL8_PIPE_SELFCHECK_EN
  logic [15:0] ref0_d, ref0_q, ref_s;
  logic        err_d, err_q;

  always_comb ref0_d = 16'(a) * 16'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref0_q <= 16'h0000;
    else        ref0_q <= ref0_d;
  end
`endif

  if (PIPE_MID != 0) begin : g_mid
    logic [15:0] psum_d, psum_q;
    logic [7:0]  am_d, am_q;
    logic [3:0]  bh_d, bh_q;
    logic        vm_d, vm_q;

    always_comb begin
      vm_d   = v0_q;
      psum_d = psum_q;
      am_d   = am_q;
      bh_d   = bh_q;
      if (v0_q) begin
        psum_d = lo_sum;
        am_d   = a0_q;
        bh_d   = b0_q[7:4];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        psum_q <= 16'h0000;
        am_q   <= 8'h00;
        bh_q   <= 4'h0;
        vm_q   <= 1'b0;
      end else begin
        psum_q <= psum_d;
        am_q   <= am_d;
        bh_q   <= bh_d;
        vm_q   <= vm_d;
      end
    end

    assign psum_s = psum_q;
    assign a_s    = am_q;
    assign bh_s   = bh_q;
    assign v_s    = vm_q;

`ifdef MUL8_PIPE_SELFCHECK_EN
    logic [15:0] refm_d, refm_q;
    always_comb refm_d = v0_q ? ref0_q : refm_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) refm_q <= 16'h0000;
      else        refm_q <= refm_d;
    end
    assign ref_s = refm_q;
`endif
  end else begin : g_nomid
    assign psum_s = lo_sum;
    assign a_s    = a0_q;
    assign bh_s   = b0_q[7:4];
    assign v_s    = v0_q;
`ifdef MUL8_PIPE_SELFCHECK_EN
    assign ref_s  = ref0_q;
`endif
  end

  always_comb begin
    hi_sum = psum_s;
    for (int i = 0; i < 4; i++) hi_sum = rca16(hi_sum, pp_row(a_s, bh_s[i], i + 4));
  end

  // Data holds across bubbles; only the valid bit follows every slot.
  always_comb begin
    ov_d   = v_s;
    dout_d = v_s ? hi_sum : dout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 16'h0000;
      ov_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      ov_q   <= ov_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = ov_q;

`ifdef MUL8_PIPE_SELFCHECK_EN
  always_comb err_d = v_s && (hi_sum != ref_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && v_s && (hi_sum != ref_s))
      $display("mul8_pipe: product %h not equal reference %h", hi_sum, ref_s);
  end
`endif
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul8_pipe.sv
// Bench for mul8_pipe: PIPE_MID=0 and PIPE_MID=1 instances share stimulus and are checked against
// a per-cycle input history (result of the pair applied L cycles earlier, data held on bubbles).
module tb_mul8_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a, b;
  logic        out_valid0, out_valid1, err0, err1;
  logic [15:0] dout0, dout1;

  int checks = 0;
  int errors = 0;

  logic        hv[$];
  logic [15:0] hp[$];
  int          cyc;
  logic        ev0, ev1;
  logic [15:0] ed0, ed1;

  always #5 clk = ~clk;

  mul8_pipe #(.PIPE_MID(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid0), .dout(dout0), .err(err0)
  );

  mul8_pipe #(.PIPE_MID(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid1), .dout(dout1), .err(err1)
  );

  task automatic reset_model();
    hv.delete();
    hp.delete();
    cyc = 0;
    ev0 = 1'b0; ev1 = 1'b0;
    ed0 = 16'h0000; ed1 = 16'h0000;
  endtask

  // Apply one input slot, advance one clock, and work out what each instance must show now.
  task automatic step(input logic v, input logic [7:0] av, input logic [7:0] bv);
    in_valid = v; a = av; b = bv;
    hv.push_back(v);
    hp.push_back(16'(int'(av) * int'(bv)));
    @(posedge clk); #1;
    cyc++;
    ev0 = 1'b0;
    if (cyc >= 2) ev0 = hv[cyc-2];
    if (ev0) ed0 = hp[cyc-2];
    ev1 = 1'b0;
    if (cyc >= 3) ev1 = hv[cyc-3];
    if (ev1) ed1 = hp[cyc-3];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid0, dout0, err0, out_valid1, dout1, err1} !== 36'h0) begin
      errors++;
      $display("FAIL reset_init: got v0=%b d0=%h e0=%b v1=%b d1=%h e1=%b want all 0",
               out_valid0, dout0, err0, out_valid1, dout1, err1);
    end
    rst_n = 1'b1;
    reset_model();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'(k + 20), 8'(k + 3));
      checks++;
      if ({out_valid0, dout0, err0, out_valid1, dout1, err1} !== {ev0, ed0, 1'b0, ev1, ed1, 1'b0})
      begin
        errors++;
        $display("FAIL reset_pre: got v0=%b d0=%h v1=%b d1=%h want v0=%b d0=%h v1=%b d1=%h",
                 out_valid0, dout0, out_valid1, dout1, ev0, ed0, ev1, ed1);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid0, dout0, err0, out_valid1, dout1, err1} !== 36'h0) begin
      errors++;
      $display("FAIL reset_async: got v0=%b d0=%h v1=%b d1=%h want all 0",
               out_valid0, dout0, out_valid1, dout1);
    end
    in_valid = 1'b1; a = 8'hAA; b = 8'h55;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    reset_model();
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'hFF, 8'hFF);
      checks++;
      if ({out_valid0, dout0, err0, out_valid1, dout1, err1} !== 36'h0) begin
        errors++;
        $display("FAIL reset_stale: got v0=%b d0=%h v1=%b d1=%h want all 0",
                 out_valid0, dout0, out_valid1, dout1);
      end
    end
  endtask

  task automatic test_corners();
    logic [7:0] ca[5];
    logic [7:0] cb[5];
    ca = '{8'd0, 8'd255, 8'd1, 8'd128, 8'd255};
    cb = '{8'd0, 8'd255, 8'd255, 8'd2, 8'd0};
    for (int n = 0; n < 5; n++) begin
      step(1'b1, ca[n], cb[n]);
      for (int k = 0; k < 4; k++) begin
        if (k > 0) step(1'b0, 8'h00, 8'h00);
        checks++;
        if ({out_valid0, dout0, err0, out_valid1, dout1, err1} !==
            {ev0, ed0, 1'b0, ev1, ed1, 1'b0}) begin
          errors++;
          $display("FAIL corner_%0d: got v0=%b d0=%h v1=%b d1=%h want v0=%b d0=%h v1=%b d1=%h",
                   n, out_valid0, dout0, out_valid1, dout1, ev0, ed0, ev1, ed1);
        end
      end
    end
    checks++;
    if (dout1 !== 16'h0000 || dout0 !== 16'h0000) begin
      errors++;
      $display("FAIL corner_last: got d0=%h d1=%h want 0000", dout0, dout1);
    end
  endtask

  task automatic test_bubbles();
    logic       bv[8];
    logic [7:0] ba[8];
    logic [7:0] bb[8];
    bv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ba = '{8'd3, 8'hEE, 8'd7, 8'd16, 8'hDD, 8'h00, 8'h00, 8'h00};
    bb = '{8'd5, 8'h77, 8'd9, 8'd16, 8'h99, 8'h00, 8'h00, 8'h00};
    for (int n = 0; n < 8; n++) begin
      step(bv[n], ba[n], bb[n]);
      checks++;
      if ({out_valid0, dout0, err0, out_valid1, dout1, err1} !== {ev0, ed0, 1'b0, ev1, ed1, 1'b0})
      begin
        errors++;
        $display("FAIL bubble_%0d: got v0=%b d0=%h v1=%b d1=%h want v0=%b d0=%h v1=%b d1=%h",
                 n, out_valid0, dout0, out_valid1, dout1, ev0, ed0, ev1, ed1);
      end
    end
    checks++;
    if (dout0 !== 16'd256 || dout1 !== 16'd256) begin
      errors++;
      $display("FAIL bubble_hold: got d0=%h d1=%h want 0100", dout0, dout1);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 259; i++) begin
      for (int j = 0; j < 256; j++) begin
        if (i < 256) step(1'b1, 8'(i), 8'(j));
        else if (j == 0) step(1'b0, 8'h00, 8'h00);
        else break;
        checks++;
        if ({out_valid0, dout0, err0, out_valid1, dout1, err1} !==
            {ev0, ed0, 1'b0, ev1, ed1, 1'b0}) begin
          errors++;
          $display("FAIL sweep_%0d_%0d: got v0=%b d0=%h e0=%b v1=%b d1=%h e1=%b want v0=%b d0=%h v1=%b d1=%h",
                   i, j, out_valid0, dout0, err0, out_valid1, dout1, err1, ev0, ed0, ev1, ed1);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
      checks++;
      if ({out_valid0, dout0, err0, out_valid1, dout1, err1} !== {ev0, ed0, 1'b0, ev1, ed1, 1'b0})
      begin
        errors++;
        $display("FAIL random_%0d: got v0=%b d0=%h v1=%b d1=%h want v0=%b d0=%h v1=%b d1=%h",
                 n, out_valid0, dout0, out_valid1, dout1, ev0, ed0, ev1, ed1);
      end
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_corners();
    test_bubbles();
    test_random();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul8_pipe.md
Name: mul8_pipe

Overview:
- Unsigned 8x8 -> 16-bit multiplier built structurally as an AND-array of partial products summed by full/half-adder rows. The `*` operator is not used in the datapath.
- Registered input capture, an optional mid-array pipeline register and a registered output, with a valid flag travelling alongside the data.
- Drop-in arithmetic unit for datapaths that need a fixed-latency product, and a golden-equivalent of the combinational 8x8 multiplier used elsewhere.

Parameters:
- PIPE_MID, default 1, meaning: 1 inserts a register after partial-product row 4; 0 removes it. Legal values are 0 and 1 only.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a and b are valid this cycle
- a  input  8  unsigned multiplicand
- b  input  8  unsigned multiplier
- out_valid  output  1  dout holds the product of a captured operand pair
- dout  output  16  unsigned product a*b
- err  output  1  self-check mismatch flag (see Optional Feature)

Behaviour:
- Reset: rst_n low asynchronously clears all pipeline data and valid registers, so out_valid=0, dout=16'h0000 and err=0. Release is synchronous to the next clk edge.
- Stage 0, capture: on each rising edge, a, b and in_valid are registered unconditionally; there is no back-pressure and no ready signal.
- Partial products: pp[i][j] = a[j] & b[i]. Rows are summed with ripple or carry-save adders, and the final row is resolved by a ripple adder.
- PIPE_MID=1: the partial sum after rows 0-3, the unused a/b bits and valid are registered.
- Output stage: the final sum is registered into dout and valid into out_valid.
- Latency: out_valid/dout appear 2 cycles after the in_valid edge for PIPE_MID=0, and 3 cycles for PIPE_MID=1.
- Throughput: one result per cycle. Back-to-back in_valid produces back-to-back out_valid in the same order.
- Width: the full 16-bit result, with no truncation or overflow. Maximum is 255*255 = 16'hFE01.
- Bubble handling: when in_valid=0, the corresponding out_valid slot is 0.
- dout when out_valid=0: holds its previous value, meaning the data registers load only when the stage valid is 1.
- Reset mid-operation: all in-flight results are discarded. No out_valid pulse occurs for operands captured before reset.
- Purity: results depend only on the captured operands; no state carries between operations.

Optional Feature:
- Macro: MUL8_PIPE_SELFCHECK_EN.
- Defined: a behavioural reference product (a*b) travels through a parallel pipeline with the same latency. On every out_valid cycle, err is registered as (dout != reference); err is 0 when out_valid=0. The block also prints a simulation-only "not equal" message on mismatch.
- Undefined: err is tied to constant 0 and no reference logic is generated.
- The port list is identical in both cases.

Test Plan:
- Reset: assert rst_n=0 mid-stream with valid data in flight -> out_valid=0 and dout=0 immediately (asynchronous); no stale out_valid after release.
- Corners: (0,0)->0, (255,255)->16'hFE01, (1,255)->255, (128,2)->256, (255,0)->0, each with out_valid exactly LATENCY cycles after capture.
- Exhaustive sweep: i=0..255, j=0..255, one pair per cycle with continuous in_valid. Each out_valid result equals i*j; the stream is in order and gap-free; err stays 0 with MUL8_PIPE_SELFCHECK_EN defined.
- Bubbles: in_valid pattern 1,0,1,1,0 with (3,5),(x),(7,9),(16,16),(x) -> out_valid 1,0,1,1,0 and dout 15, held 15, 63, 256, held 256.
- Parameter sweep: repeat the corner test with PIPE_MID=0 and PIPE_MID=1 -> latency 2 and 3 respectively; identical products.
- Macro off: build without MUL8_PIPE_SELFCHECK_EN -> err constant 0 across the full sweep; products unchanged.
